// File: rtl/pll_reset_sequencer_pkg.sv
// Shared definitions for the PLL reset sequencer: debug state encodings,
// the state width, and a counter-width helper.
package pll_reset_sequencer_pkg;

  localparam int unsigned STATE_W = 3;

  // Values are the debug encoding visible on the state port.
  typedef enum logic [STATE_W-1:0] {
    StPllRst   = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StRelease  = 3'd3,
    StRun      = 3'd4,
    StFault    = 3'd5
  } pll_state_e;

  // Bits needed to hold values 0..n (at least 1).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; output settles two edges after the input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: holds the PLL in reset, waits for a qualified lock with
// timeout/retry, then releases downstream domain resets one at a time.
// Optional build macro PLL_LOCK_LOSS_COUNT_EN adds the lock_loss_count port.
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int unsigned RESET_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned NUM_DOMAINS   = 3,
  parameter int unsigned STAGGER       = 8,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned CNT_W         = 8,
  localparam int unsigned RC_W         = cnt_width(MAX_RETRIES)
) (
  input  logic                   clock_in,
  input  logic                   reset,
  input  logic                   restart,
  input  logic                   locked,
  output logic                   pll_resetb,
  output logic [NUM_DOMAINS-1:0] domain_reset,
  output logic                   ready,
  output logic                   fault,
  output logic [RC_W-1:0]        retry_count,
  output logic [STATE_W-1:0]     state
`ifdef PLL_LOCK_LOSS_COUNT_EN
  ,
  output logic [CNT_W-1:0]       lock_loss_count
`endif
);

  localparam int unsigned RstW  = cnt_width(RESET_CYCLES);
  localparam int unsigned TmrW  = cnt_width(LOCK_TIMEOUT);
  localparam int unsigned StabW = cnt_width(STABLE_CYCLES);
  localparam int unsigned RelW  = cnt_width(STAGGER);

  logic lock_s;

  sync_2ff u_lock_sync (
    .clk   (clock_in),
    .reset (reset),
    .d     (locked),
    .q     (lock_s)
  );

  pll_state_e             state_q, state_d;
  logic [RstW-1:0]        rst_cnt_q, rst_cnt_d;
  logic [TmrW-1:0]        tmr_q, tmr_d;
  logic [StabW-1:0]       stab_cnt_q, stab_cnt_d;
  logic [RelW-1:0]        rel_cnt_q, rel_cnt_d;
  logic [NUM_DOMAINS-1:0] dom_rst_q, dom_rst_d;
  logic [RC_W-1:0]        retry_q, retry_d;
  logic                   pll_resetb_q, pll_resetb_d;
  logic                   ready_q, ready_d;
  logic                   fault_q, fault_d;
  logic                   timeout;
  logic                   rel_tick;

  // Timer is checked with >= because it keeps running through STABLE.
  assign timeout  = (tmr_q >= TmrW'(LOCK_TIMEOUT - 1));
  assign rel_tick = (rel_cnt_q == RelW'(STAGGER - 1));

  // Next-state and retry bookkeeping; restart overrides everything else.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    if (restart) begin
      state_d = StPllRst;
      retry_d = '0;
    end else begin
      unique case (state_q)
        StPllRst: begin
          if (rst_cnt_q == RstW'(RESET_CYCLES - 1)) state_d = StWaitLock;
        end
        StWaitLock: begin
          if (lock_s) begin
            state_d = StStable;
          end else if (timeout) begin
            if (retry_q == RC_W'(MAX_RETRIES)) begin
              state_d = StFault;
            end else begin
              retry_d = retry_q + RC_W'(1);
              state_d = StPllRst;
            end
          end
        end
        StStable: begin
          if (!lock_s) begin
            state_d = StWaitLock;
          end else if (stab_cnt_q == StabW'(STABLE_CYCLES - 1)) begin
            state_d = StRelease;
          end
        end
        StRelease: begin
          if (!lock_s) begin
            state_d = StPllRst;
          end else if (dom_rst_q == '0) begin
            state_d = StRun;
            retry_d = '0;
          end
        end
        StRun: begin
          if (!lock_s) state_d = StPllRst;
        end
        StFault: state_d = StFault;
        default: state_d = StPllRst;
      endcase
    end
  end

  // Counters, release shifter and registered outputs derived from next state.
  always_comb begin
    rst_cnt_d = '0;
    if (!restart && state_q == StPllRst && state_d == StPllRst) begin
      rst_cnt_d = rst_cnt_q + RstW'(1);
    end

    tmr_d = '0;
    if (state_q == StWaitLock || state_q == StStable) begin
      tmr_d = (tmr_q == '1) ? tmr_q : tmr_q + TmrW'(1);
    end

    stab_cnt_d = '0;
    if (state_q == StStable && state_d == StStable) begin
      stab_cnt_d = stab_cnt_q + StabW'(1);
    end

    rel_cnt_d = '0;
    if (state_q == StRelease && state_d == StRelease && !rel_tick) begin
      rel_cnt_d = rel_cnt_q + RelW'(1);
    end

    dom_rst_d = '1;
    if (state_q == StRelease && state_d == StRelease) begin
      // Shifting in zeros from the bottom releases bit 0 first.
      dom_rst_d = rel_tick ? (dom_rst_q << 1) : dom_rst_q;
    end else if (state_d == StRun) begin
      dom_rst_d = '0;
    end

    pll_resetb_d = !(state_d == StPllRst || state_d == StFault);
    ready_d      = (state_d == StRun);
    fault_d      = (state_d == StFault);
  end

  // State and output registers.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q      <= StPllRst;
      rst_cnt_q    <= '0;
      tmr_q        <= '0;
      stab_cnt_q   <= '0;
      rel_cnt_q    <= '0;
      dom_rst_q    <= '1;
      retry_q      <= '0;
      pll_resetb_q <= 1'b0;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      tmr_q        <= tmr_d;
      stab_cnt_q   <= stab_cnt_d;
      rel_cnt_q    <= rel_cnt_d;
      dom_rst_q    <= dom_rst_d;
      retry_q      <= retry_d;
      pll_resetb_q <= pll_resetb_d;
      ready_q      <= ready_d;
      fault_q      <= fault_d;
    end
  end

  assign pll_resetb   = pll_resetb_q;
  assign domain_reset = dom_rst_q;
  assign ready        = ready_q;
  assign fault        = fault_q;
  assign retry_count  = retry_q;
  assign state        = state_q;

`ifdef PLL_LOCK_LOSS_COUNT_EN
  logic             lock_loss;
  logic [CNT_W-1:0] llc_q;

  assign lock_loss = !restart && !lock_s && (state_q == StRelease || state_q == StRun);

  // Saturating lock-loss counter; restart deliberately leaves it alone.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      llc_q <= '0;
    end else if (lock_loss && llc_q != '1) begin
      llc_q <= llc_q + CNT_W'(1);
    end
  end

  assign lock_loss_count = llc_q;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer with small timing parameters.
module tb_pll_reset_sequencer;

  localparam int unsigned RC  = 4;
  localparam int unsigned TO  = 32;
  localparam int unsigned SC  = 8;
  localparam int unsigned ND  = 3;
  localparam int unsigned SG  = 2;
  localparam int unsigned MR  = 2;
  localparam int unsigned CW  = 8;
  localparam int unsigned RCW = $clog2(MR + 1);

  logic          clk     = 1'b0;
  logic          reset   = 1'b1;
  logic          restart = 1'b0;
  logic          locked  = 1'b0;
  logic          pll_resetb;
  logic [ND-1:0] domain_reset;
  logic          ready;
  logic          fault;
  logic [RCW-1:0] retry_count;
  logic [2:0]    state;
`ifdef PLL_LOCK_LOSS_COUNT_EN
  logic [CW-1:0] lock_loss_count;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state: phase number, cycles spent in phase, timers.
  int   m_st, m_el, m_tmr, m_rc, m_llc;
  logic m_s1, m_s2;
  logic chat_win = 1'b0;
  logic saw_rel  = 1'b0;

  pll_reset_sequencer #(
    .RESET_CYCLES  (RC),
    .LOCK_TIMEOUT  (TO),
    .STABLE_CYCLES (SC),
    .NUM_DOMAINS   (ND),
    .STAGGER       (SG),
    .MAX_RETRIES   (MR),
    .CNT_W         (CW)
  ) dut (
    .clock_in        (clk),
    .reset           (reset),
    .restart         (restart),
    .locked          (locked),
    .pll_resetb      (pll_resetb),
    .domain_reset    (domain_reset),
    .ready           (ready),
    .fault           (fault),
    .retry_count     (retry_count),
    .state           (state)
`ifdef PLL_LOCK_LOSS_COUNT_EN
    ,
    .lock_loss_count (lock_loss_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, got, exp, cyc, $time);
    end
  endtask

  // Domain resets as a function of phase: in RELEASE one more bit drops every SG cycles.
  function automatic logic [ND-1:0] exp_dr(input int st, input int el);
    logic [ND-1:0] ones;
    ones = '1;
    if (st == 3) return ones << (el / SG);
    if (st == 4) return '0;
    return ones;
  endfunction

  // Behavioural model, stepped on the same edges as the DUT.
  always @(posedge clk or posedge reset) begin : model
    int   st, el, rc, llc;
    logic lk, to_hit;
    if (reset) begin
      m_st <= 0; m_el <= 0; m_tmr <= 0; m_rc <= 0; m_llc <= 0;
      m_s1 <= 1'b0; m_s2 <= 1'b0;
    end else begin
      st = m_st; el = m_el; rc = m_rc; llc = m_llc;
      lk = m_s2;
      to_hit = (m_tmr >= TO - 1);
      if (restart) begin
        st = 0; el = 0; rc = 0;
      end else begin
        case (m_st)
          0: if (el == RC - 1) begin st = 1; el = 0; end else el++;
          1: if (lk) begin
               st = 2; el = 0;
             end else if (to_hit) begin
               if (rc == MR) st = 5;
               else begin rc++; st = 0; end
               el = 0;
             end
          2: if (!lk) begin st = 1; el = 0; end
             else if (el + 1 == SC) begin st = 3; el = 0; end
             else el++;
          3: if (!lk) begin st = 0; el = 0; if (llc < 255) llc++; end
             else if (el == ND * SG) begin st = 4; el = 0; rc = 0; end
             else el++;
          4: if (!lk) begin st = 0; el = 0; if (llc < 255) llc++; end
          default: ;
        endcase
      end
      m_tmr <= (m_st == 1 || m_st == 2) ? m_tmr + 1 : 0;
      m_st  <= st;
      m_el  <= el;
      m_rc  <= rc;
      m_llc <= llc;
      m_s2  <= m_s1;
      m_s1  <= locked;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (!reset) begin
      check("state", state, m_st);
      check("pll_resetb", pll_resetb, (m_st >= 1 && m_st <= 4));
      check("domain_reset", domain_reset, exp_dr(m_st, m_el));
      check("ready", ready, (m_st == 4));
      check("fault", fault, (m_st == 5));
      check("retry_count", retry_count, m_rc);
`ifdef PLL_LOCK_LOSS_COUNT_EN
      check("lock_loss_count", lock_loss_count, m_llc);
`endif
      if (chat_win && state == 3'd3) saw_rel <= 1'b1;
    end
  end

  task automatic at(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) begin
      checks++;
      errors++;
      $display("FAIL schedule: got cycle %0d expected %0d", cyc, n);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    check("rst state", state, 0);
    check("rst pll_resetb", pll_resetb, 0);
    check("rst domain_reset", domain_reset, 3'b111);
    check("rst ready", ready, 0);
    check("rst fault", fault, 0);
    check("rst retry", retry_count, 0);

    // Clean lock
    at(3);  check("t1 c3 state", state, 0); check("t1 c3 resetb", pll_resetb, 0);
    at(4);  check("t1 c4 state", state, 1); check("t1 c4 resetb", pll_resetb, 1);
    at(10); locked = 1'b1;
    at(13); check("t1 c13 state", state, 2);
    at(21); check("t1 c21 state", state, 3); check("t1 c21 dr", domain_reset, 3'b111);
    at(23); check("t1 c23 dr", domain_reset, 3'b110);
    at(25); check("t1 c25 dr", domain_reset, 3'b100);
    at(27); check("t1 c27 dr", domain_reset, 3'b000); check("t1 c27 state", state, 3);
    at(28); check("t1 ready", ready, 1); check("t1 state", state, 4);

    // Lock loss in RUN, then relock
    at(30); locked = 1'b0;
    at(32); check("t2 c32 state", state, 4);
    at(33); check("t2 state", state, 0); check("t2 dr", domain_reset, 3'b111);
    check("t2 ready", ready, 0);
`ifdef PLL_LOCK_LOSS_COUNT_EN
    check("t2 llc", lock_loss_count, 1);
`endif
    locked = 1'b1;
    at(53); check("t2 relock ready", ready, 1); check("t2 relock state", state, 4);

    // One timeout, then lock loss mid-RELEASE
    at(60); restart = 1'b1; locked = 1'b0;
    at(61); restart = 1'b0;
    at(96); check("t3 c96 state", state, 1); check("t3 c96 retry", retry_count, 0);
    at(97); check("t3 c97 state", state, 0); check("t3 c97 retry", retry_count, 1);
    locked = 1'b1;
    at(112); check("t3 c112 dr", domain_reset, 3'b110); check("t3 c112 state", state, 3);
    at(113); locked = 1'b0;
    at(116); check("t3 state", state, 0); check("t3 dr", domain_reset, 3'b111);
    check("t3 retry kept", retry_count, 1);
`ifdef PLL_LOCK_LOSS_COUNT_EN
    check("t3 llc", lock_loss_count, 2);
`endif

    // Never lock -> FAULT, then restart
    at(120); restart = 1'b1;
    at(121); restart = 1'b0;
    at(192); check("t4 c192 state", state, 1); check("t4 c192 retry", retry_count, 1);
    at(193); check("t4 c193 state", state, 0); check("t4 c193 retry", retry_count, 2);
    at(229); check("t4 state", state, 5); check("t4 fault", fault, 1);
    check("t4 resetb", pll_resetb, 0); check("t4 dr", domain_reset, 3'b111);
    check("t4 retry", retry_count, 2);
    at(235); restart = 1'b1;
    at(236); restart = 1'b0;
    check("t4 restart state", state, 0); check("t4 restart fault", fault, 0);
    check("t4 restart retry", retry_count, 0);

    // Chattering lock: toggles every 5 cycles
    chat_win = 1'b1;
    for (int k = 0; k < 20; k++) begin
      at(236 + 5 * k);
      locked = (k % 2 == 0);
    end
    at(336);
    chat_win = 1'b0;
    check("t5 no release", saw_rel, 0);
    check("t5 retried", (retry_count != 0), 1);
    check("t5 dr", domain_reset, 3'b111);

    // Async reset mid-RELEASE
    at(340); restart = 1'b1; locked = 1'b1;
    at(341); restart = 1'b0;
    at(357); check("t6 pre dr", domain_reset, 3'b110); check("t6 pre state", state, 3);
    #2 reset = 1'b1;
    #1;
    check("t6 async state", state, 0);
    check("t6 async resetb", pll_resetb, 0);
    check("t6 async dr", domain_reset, 3'b111);
    check("t6 async ready", ready, 0);
    check("t6 async fault", fault, 0);
    check("t6 async retry", retry_count, 0);
    @(negedge clk);
    #2 reset = 1'b0;
    at(20); check("t6 rerun ready", ready, 1); check("t6 rerun state", state, 4);
`ifdef PLL_LOCK_LOSS_COUNT_EN
    check("t6 llc cleared", lock_loss_count, 0);
`endif
    at(25);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
